// File: rtl/uart_rx_framer.sv
// UART receive framer: validates the start bit, samples data LSB-first at mid-bit,
// checks the stop bit and emits the word with a one-cycle valid or framing-error strobe.
module uart_rx_framer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic                 start_pulse_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, ferr_d, busy_d;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_o;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_pulse_i) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          // A line that is already high again at mid-start-bit was a glitch
          state_d = rx_i ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_i;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          // Returning at mid-stop-bit leaves room to catch a back-to-back start edge
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_i) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_o      <= data_d;
      valid_o     <= valid_d;
      frame_err_o <= ferr_d;
      busy_o      <= busy_d;
    end
  end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Serial-to-parallel receive stage of the UART controller.
- Sits directly downstream of the falling-edge pulse detector, which watches the synchronized RX line. That detector's one-cycle pulse marks a candidate start bit.
- This block times the bit periods, validates the start bit, samples the data bits LSB-first at mid-bit, checks the stop bit, and presents the received word with a one-cycle valid or framing-error strobe.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200). Legal range >= 4.
- DATA_BITS, 8, data bits per frame. Legal range 5..9.
- Derived constant HALF = (CLKS_PER_BIT-1)/2, integer division. Not overridable.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge
- rst_i  input  1  synchronous, active-high reset
- rx_i  input  1  synchronized serial RX level; idle = 1
- start_pulse_i  input  1  one-cycle pulse on each falling edge of rx_i, from the edge detector
- data_o  output  DATA_BITS  last correctly framed word, LSB = first bit received
- valid_o  output  1  one-cycle strobe: data_o has just been updated
- frame_err_o  output  1  one-cycle strobe: stop bit sampled as 0
- busy_o  output  1  high whenever state is not IDLE

Interface (already decided):
- One clock.
- Reset is synchronous and active-high on rst_i, sampled at the rising edge of clk_i.

Behaviour:
- Reset:
  - state = IDLE; bit counter, cycle counter and shift register = 0.
  - data_o = 0, valid_o = 0, frame_err_o = 0, busy_o = 0.
  - Reset has priority over every other input. Asserting it mid-frame abandons the frame with no strobe.
- All outputs are registered.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE. Cycle counter cnt has width clog2(CLKS_PER_BIT).
- IDLE:
  - start_pulse_i = 1 -> START, cnt = 0.
  - rx_i alone never starts a frame.
- START:
  - cnt increments each cycle.
  - At cnt == HALF, sample rx_i.
  - If the sample is 0 -> DATA, cnt = 0, bit index = 0.
  - If the sample is 1 -> false start (glitch): return to IDLE with no strobe.
- DATA:
  - cnt counts 0..CLKS_PER_BIT-1.
  - At cnt == CLKS_PER_BIT-1, sample rx_i into shift-register position [bit index], then cnt = 0 and bit index increments.
  - After the DATA_BITS-th sample -> STOP.
- STOP:
  - At cnt == CLKS_PER_BIT-1, sample rx_i and return to IDLE.
  - Sample = 1: next cycle data_o <= shift register and valid_o = 1 for exactly one cycle.
  - Sample = 0: next cycle frame_err_o = 1 for exactly one cycle; data_o keeps its previous value.
- Strobes: valid_o and frame_err_o are never high together and never high for two consecutive cycles from one frame.
- Latency: with the start pulse at cycle T, valid_o or frame_err_o is high at cycle T + 2 + HALF + (DATA_BITS+1)*CLKS_PER_BIT.
- busy_o: high from cycle T+1 through the stop-sample cycle. It is low in the cycle the strobe is high.
- start_pulse_i while not in IDLE:
  - Ignored, including on the stop-sample cycle.
  - Because the FSM returns to IDLE at mid-stop-bit, the start edge of a back-to-back frame arrives after the return and is caught.
- Break condition (rx_i held 0): only one frame_err_o is produced. No new frame starts until a fresh start_pulse_i.

Test Plan:
- Use CLKS_PER_BIT = 16 (HALF = 7) and DATA_BITS = 8 throughout.
- Reset, then send 0xA5 with a correct stop bit, start pulse at cycle T -> valid_o = 1 only at T+153, data_o = 0xA5, frame_err_o stays 0.
- Send 0x3C then 0xC3 back-to-back, zero idle bits between frames -> two valid_o strobes 160 cycles apart, data_o = 0x3C then 0xC3.
- Start pulse with rx_i back to 1 within 3 cycles -> FSM returns to IDLE at T+8; no strobe; busy_o high T+1..T+8 only.
- Send 0x55 with the stop bit = 0 -> frame_err_o = 1 at T+153, valid_o = 0, data_o keeps its prior value (0xC3).
- Assert rst_i for 1 cycle during data bit 4 of a frame -> all outputs 0 the next cycle, no strobe; a following frame 0x81 is received correctly.
- Hold rx_i = 0 for 30 bit times after a start pulse, with spurious start pulses mid-frame -> exactly one frame_err_o, spurious pulses ignored, no valid_o.
